// File: rtl/sa_feed_pkg.sv
// sa_feed_pkg
//   Shared definitions for the systolic-array operand feeder:
//   - state_t   : feeder FSM states
//   - flush_len : zero beats needed after the last operand beat so the
//                 farthest PE (row HPE-1, column HPE-1) has absorbed it
//   - lane_lsb  : LSB index of lane z in a packed lane bus
package sa_feed_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH,
        DONE
    } state_t;

    // Lane skew (HPE-1) plus in-array propagation (HPE-1) plus MAC pipeline.
    function automatic int unsigned flush_len(input int unsigned hpe,
                                              input int unsigned pipe_lat);
        return 2 * (hpe - 1) + pipe_lat;
    endfunction

    function automatic int unsigned lane_lsb(input int unsigned lane,
                                             input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/sa_skew_line.sv
// sa_skew_line
//   WIDTH-bit shift register of DEPTH stages with asynchronous active-low
//   clear. One instance per operand lane provides that lane's skew delay.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low clear of all stages
//   i_d      data into stage 0
//   o_q      data out of stage DEPTH-1 (always registered)
module sa_skew_line #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_sr [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_sr[i] <= '0;
            end
        end else begin
            r_sr[0] <= i_d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/sa_feed_skewer.sv
// sa_feed_skewer
//   Upstream feeder for an output-stationary HPE x HPE systolic array.
//   Accepts one A column-vector and one B row-vector per beat for a tile of
//   depth k_len, diagonally skews them (lane z delayed z extra cycles) onto
//   AA/BB, fills idle cycles and the flush tail with zero beats, and marks
//   tile start (acc_clr) and tile completion (tile_done).
// Ports:
//   CLK        clock
//   RST        asynchronous active-low reset
//   start      one-cycle tile start request (honoured only in IDLE)
//   k_len      tile depth, sampled with start
//   in_valid   a_vec/b_vec beat valid
//   in_ready   beat can be accepted (LOAD only)
//   a_vec      A lanes, lane z = bits[(z+1)*WIDTH-1 : z*WIDTH]
//   b_vec      B lanes, same packing
//   AA, BB     skewed operand buses to the array (fully registered)
//   busy       tile in progress
//   acc_clr    pulse aligned with the first beat on lane 0
//   tile_done  pulse once every MAC output of the tile is final
module sa_feed_skewer
    import sa_feed_pkg::*;
#(
    parameter int unsigned HPE      = 64,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned K_MAX    = 1024,
    parameter int unsigned PIPE_LAT = 2,
    parameter int unsigned KW       = $clog2(K_MAX + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic [KW-1:0]        k_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH*HPE-1:0] a_vec,
    input  logic [WIDTH*HPE-1:0] b_vec,
    output logic [WIDTH*HPE-1:0] AA,
    output logic [WIDTH*HPE-1:0] BB,
    output logic                 busy,
    output logic                 acc_clr,
    output logic                 tile_done
);

    localparam int unsigned FW         = $clog2(2 * HPE + PIPE_LAT);
    localparam logic [FW-1:0] FLUSH_INIT = FW'(flush_len(HPE, PIPE_LAT));

    state_t               r_state;
    state_t               w_state_nxt;
    logic [KW-1:0]        r_k_len;
    logic [KW-1:0]        r_beat_cnt;
    logic [FW-1:0]        r_flush_cnt;
    logic                 r_acc_clr;
    logic                 w_accept;
    logic                 w_last_beat;
    logic [WIDTH*HPE-1:0] w_a_in;
    logic [WIDTH*HPE-1:0] w_b_in;

    assign w_accept    = in_valid && (r_state == LOAD);
    assign w_last_beat = w_accept && ((r_beat_cnt + KW'(1)) == r_k_len);

    // The array never stalls: any cycle without an accepted beat feeds zeros.
    assign w_a_in = w_accept ? a_vec : '0;
    assign w_b_in = w_accept ? b_vec : '0;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b1;
        tile_done   = 1'b0;
        unique case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = (k_len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (w_last_beat) begin
                    w_state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (r_flush_cnt == FW'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                tile_done   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_k_len     <= '0;
            r_beat_cnt  <= '0;
            r_flush_cnt <= '0;
            r_acc_clr   <= 1'b0;
        end else begin
            // First beat of the tile reaches lane 0 one cycle after acceptance.
            r_acc_clr <= w_accept && (r_beat_cnt == '0);

            if ((r_state == IDLE) && start && (k_len != '0)) begin
                r_k_len    <= k_len;
                r_beat_cnt <= '0;
            end else if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + KW'(1);
            end

            if (w_last_beat) begin
                r_flush_cnt <= FLUSH_INIT;
            end else if (r_state == FLUSH) begin
                r_flush_cnt <= r_flush_cnt - FW'(1);
            end
        end
    end

    assign acc_clr = r_acc_clr;

    for (genvar z = 0; z < HPE; z++) begin : g_lane
        sa_skew_line #(
            .WIDTH(WIDTH),
            .DEPTH(z + 1)
        ) u_skew_a (
            .i_clk  (CLK),
            .i_rst_n(RST),
            .i_d    (w_a_in[lane_lsb(z, WIDTH) +: WIDTH]),
            .o_q    (AA[lane_lsb(z, WIDTH) +: WIDTH])
        );

        sa_skew_line #(
            .WIDTH(WIDTH),
            .DEPTH(z + 1)
        ) u_skew_b (
            .i_clk  (CLK),
            .i_rst_n(RST),
            .i_d    (w_b_in[lane_lsb(z, WIDTH) +: WIDTH]),
            .o_q    (BB[lane_lsb(z, WIDTH) +: WIDTH])
        );
    end

endmodule

// File: tb/tb_sa_feed_skewer.sv
// tb_sa_feed_skewer
//   Directed bench for sa_feed_skewer (HPE=4, WIDTH=8, PIPE_LAT=2).
//   Each accepted beat schedules per-lane expected AA/BB bytes at cycle
//   t+1+z; expected acc_clr / tile_done cycles are queued likewise. A
//   negedge monitor pops and checks every cycle (unscheduled lanes must be 0).
//   A behavioural 4x4 output-stationary array fed from AA/BB is checked
//   against reference dot products at tile_done.
module tb_sa_feed_skewer;

    localparam int unsigned HPE      = 4;
    localparam int unsigned WIDTH    = 8;
    localparam int unsigned K_MAX    = 1024;
    localparam int unsigned PIPE_LAT = 2;
    localparam int unsigned KW       = $clog2(K_MAX + 1);
    localparam int unsigned VW       = WIDTH * HPE;
    localparam int          FLUSH    = 2 * (HPE - 1) + PIPE_LAT;

    logic          CLK = 1'b0;
    logic          RST;
    logic          start;
    logic [KW-1:0] k_len;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] a_vec;
    logic [VW-1:0] b_vec;
    logic [VW-1:0] AA;
    logic [VW-1:0] BB;
    logic          busy;
    logic          acc_clr;
    logic          tile_done;

    sa_feed_skewer #(
        .HPE     (HPE),
        .WIDTH   (WIDTH),
        .K_MAX   (K_MAX),
        .PIPE_LAT(PIPE_LAT),
        .KW      (KW)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .k_len    (k_len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_vec    (a_vec),
        .b_vec    (b_vec),
        .AA       (AA),
        .BB       (BB),
        .busy     (busy),
        .acc_clr  (acc_clr),
        .tile_done(tile_done)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         due;
        int         lane;
        logic [7:0] a;
        logic [7:0] b;
    } sb_t;

    sb_t sb_q[$];
    int  clr_q[$];
    int  done_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- per-cycle monitor ----------------
    always @(negedge CLK) begin : mon
        logic [VW-1:0] ea;
        logic [VW-1:0] eb;
        logic          ec;
        logic          ed;
        ea = '0;
        eb = '0;
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].due == cyc) begin
                ea[sb_q[i].lane*WIDTH +: WIDTH] = sb_q[i].a;
                eb[sb_q[i].lane*WIDTH +: WIDTH] = sb_q[i].b;
                sb_q.delete(i);
            end
        end
        ec = (clr_q.size() != 0) && (clr_q[0] == cyc);
        if (ec) void'(clr_q.pop_front());
        ed = (done_q.size() != 0) && (done_q[0] == cyc);
        if (ed) void'(done_q.pop_front());
        chk("AA", 64'(AA), 64'(ea));
        chk("BB", 64'(BB), 64'(eb));
        chk("acc_clr", 64'(acc_clr), 64'(ec));
        chk("tile_done", 64'(tile_done), 64'(ed));
    end

    // ---------------- behavioural 4x4 output-stationary array ----------------
    logic [7:0]  apre [HPE];
    logic [7:0]  bpre [HPE];
    logic [7:0]  ar   [HPE][HPE];
    logic [7:0]  br   [HPE][HPE];
    logic [31:0] acc  [HPE][HPE];

    function automatic logic [31:0] a_at(input int i, input int j);
        return (j == 0) ? {24'b0, apre[i]} : {24'b0, ar[i][j-1]};
    endfunction

    function automatic logic [31:0] b_at(input int i, input int j);
        return (i == 0) ? {24'b0, bpre[j]} : {24'b0, br[i-1][j]};
    endfunction

    always @(posedge CLK) begin
        for (int i = 0; i < HPE; i++) begin
            apre[i] <= AA[i*WIDTH +: WIDTH];
            bpre[i] <= BB[i*WIDTH +: WIDTH];
        end
        for (int i = 0; i < HPE; i++) begin
            for (int j = 0; j < HPE; j++) begin
                ar[i][j]  <= a_at(i, j)[7:0];
                br[i][j]  <= b_at(i, j)[7:0];
                acc[i][j] <= acc_clr ? 32'd0 : acc[i][j] + a_at(i, j) * b_at(i, j);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // One cycle of stimulus; when acc is set the beat is expected to be
    // accepted and its lanes are scheduled at cycle t+1+z.
    task automatic step(input logic st, input logic [KW-1:0] k, input logic v,
                        input logic [VW-1:0] a, input logic [VW-1:0] b,
                        input logic acc, input logic first);
        start    = st;
        k_len    = k;
        in_valid = v;
        a_vec    = a;
        b_vec    = b;
        if (acc) begin
            for (int z = 0; z < HPE; z++) begin
                sb_q.push_back('{due: cyc + 1 + z, lane: z,
                                 a: a[z*WIDTH +: WIDTH], b: b[z*WIDTH +: WIDTH]});
            end
            if (first) clr_q.push_back(cyc + 1);
        end
        @(posedge CLK);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        a_vec    = '0;
        b_vec    = '0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge CLK);
            #1;
        end
    endtask

    int            s;
    int            seen;
    logic [7:0]    ga [5][HPE];
    logic [7:0]    gb [5][HPE];
    logic [31:0]   ref_c [HPE][HPE];
    logic [VW-1:0] va;
    logic [VW-1:0] vb;

    initial begin
        RST      = 1'b0;
        start    = 1'b0;
        k_len    = '0;
        in_valid = 1'b0;
        a_vec    = '0;
        b_vec    = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        RST = 1'b1;
        @(posedge CLK);
        #1;

        // --- k_len=3 back-to-back; in_valid with start must be ignored;
        //     start during FLUSH must be ignored
        s = cyc;
        done_q.push_back(s + 3 + FLUSH + 1);
        step(1'b1, KW'(3), 1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 1'b0);
        chk("t1_in_ready_load", 64'(in_ready), 64'd1);
        chk("t1_busy_load", 64'(busy), 64'd1);
        step(1'b0, '0, 1'b1, 32'h04030201, 32'h40302010, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 32'h08070605, 32'h80706050, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 32'h0C0B0A09, 32'hC0B0A090, 1'b1, 1'b0);
        chk("t1_in_ready_flush", 64'(in_ready), 64'd0);
        chk("t1_busy_flush", 64'(busy), 64'd1);
        step(1'b1, KW'(3), 1'b1, 32'h11111111, 32'h22222222, 1'b0, 1'b0);
        wait_until(s + 13);
        chk("t1_busy_after", 64'(busy), 64'd0);
        wait_until(s + 20);
        chk("t1_idle_ready", 64'(in_ready), 64'd0);

        // --- k_len=3 with a 2-cycle bubble: tile_done 2 cycles later
        s = cyc;
        done_q.push_back(s + 3 + FLUSH + 1 + 2);
        step(1'b1, KW'(3), 1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 32'h14131211, 32'h24232221, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("t2_in_ready_bubble", 64'(in_ready), 64'd1);
        step(1'b0, '0, 1'b1, 32'h18171615, 32'h28272625, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 32'h1C1B1A19, 32'h2C2B2A29, 1'b1, 1'b0);
        wait_until(s + 15);
        chk("t2_busy_after", 64'(busy), 64'd0);
        wait_until(s + 18);

        // --- k_len=0: straight to DONE, no data, no acc_clr
        s = cyc;
        done_q.push_back(s + 1);
        step(1'b1, KW'(0), 1'b1, 32'h55555555, 32'h66666666, 1'b0, 1'b0);
        chk("t3_in_ready", 64'(in_ready), 64'd0);
        chk("t3_busy_done", 64'(busy), 64'd1);
        step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("t3_busy_after", 64'(busy), 64'd0);
        wait_until(s + 5);

        // --- reset mid-LOAD after 2 beats: tile aborted, no tile_done
        s = cyc;
        step(1'b1, KW'(3), 1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 32'h31323334, 32'h41424344, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 32'h35363738, 32'h45464748, 1'b1, 1'b0);
        RST = 1'b0;
        sb_q.delete();
        #1;
        chk("t4_AA_rst", 64'(AA), 64'd0);
        chk("t4_BB_rst", 64'(BB), 64'd0);
        chk("t4_busy_rst", 64'(busy), 64'd0);
        chk("t4_in_ready_rst", 64'(in_ready), 64'd0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        wait_until(s + 25);

        // --- golden: K=5 random 4x4 tile through the array model
        for (int k = 0; k < 5; k++) begin
            for (int z = 0; z < HPE; z++) begin
                ga[k][z] = 8'($urandom_range(255));
                gb[k][z] = 8'($urandom_range(255));
            end
        end
        for (int i = 0; i < HPE; i++) begin
            for (int j = 0; j < HPE; j++) begin
                ref_c[i][j] = 32'd0;
                for (int k = 0; k < 5; k++) begin
                    ref_c[i][j] = ref_c[i][j] + {24'b0, ga[k][i]} * {24'b0, gb[k][j]};
                end
            end
        end
        s = cyc;
        done_q.push_back(s + 5 + FLUSH + 1);
        step(1'b1, KW'(5), 1'b0, '0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            for (int z = 0; z < HPE; z++) begin
                va[z*WIDTH +: WIDTH] = ga[k][z];
                vb[z*WIDTH +: WIDTH] = gb[k][z];
            end
            step(1'b0, '0, 1'b1, va, vb, 1'b1, (k == 0));
        end
        seen = 0;
        for (int n = 0; n < 40 && seen == 0; n++) begin
            if (tile_done === 1'b1) seen = 1;
            else begin
                @(posedge CLK);
                #1;
            end
        end
        chk("t5_done_seen", 64'(seen), 64'd1);
        for (int i = 0; i < HPE; i++) begin
            for (int j = 0; j < HPE; j++) begin
                chk($sformatf("t5_mac_%0d_%0d", i, j), 64'(acc[i][j]), 64'(ref_c[i][j]));
            end
        end
        wait_until(cyc + 4);

        chk("queues_drained", 64'(sb_q.size() + clr_q.size() + done_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
